// File: rtl/vin_spc_pkg.sv
// Shared constants and types for the VIN serial-programmed configuration block.
// Build option: LED_ACTIVE_LOW_EN (see vin_spc_top).
package vin_spc_pkg;

  localparam int unsigned CFG_W    = 33;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned PAGE_MAX = 4;
  localparam int unsigned PAGE_W   = 3;
  localparam int unsigned LED_W    = 8;
  localparam int unsigned NUM_BTN  = 4;

  localparam int unsigned BTN_LEFT  = 0;
  localparam int unsigned BTN_RIGHT = 1;
  localparam int unsigned BTN_UP    = 2;
  localparam int unsigned BTN_DOWN  = 3;

  localparam int unsigned RE_POS         = 0;  localparam int unsigned RE_W         = 1;
  localparam int unsigned FS_POS         = 1;  localparam int unsigned FS_W         = 1;
  localparam int unsigned GD_POS         = 2;  localparam int unsigned GD_W         = 3;
  localparam int unsigned NS_POS         = 5;  localparam int unsigned NS_W         = 1;
  localparam int unsigned CE_POS         = 6;  localparam int unsigned CE_W         = 1;
  localparam int unsigned GS_POS         = 7;  localparam int unsigned GS_W         = 4;
  localparam int unsigned IQ_POS         = 11; localparam int unsigned IQ_W         = 1;
  localparam int unsigned F_POS          = 12; localparam int unsigned F_W          = 4;
  localparam int unsigned CAP_SEL_POS    = 16; localparam int unsigned CAP_SEL_W    = 4;
  localparam int unsigned CCOMP_SEL_POS  = 20; localparam int unsigned CCOMP_SEL_W  = 2;
  localparam int unsigned EN_RDEG_HF_POS = 22; localparam int unsigned EN_RDEG_HF_W = 2;
  localparam int unsigned EN_RDEG_POS    = 24; localparam int unsigned EN_RDEG_W    = 1;
  localparam int unsigned DP_POS         = 25; localparam int unsigned DP_W         = 3;
  localparam int unsigned DN_POS         = 28; localparam int unsigned DN_W         = 2;
  localparam int unsigned EN_HF_POS      = 30; localparam int unsigned EN_HF_W      = 1;
  localparam int unsigned EN_MF_POS      = 31; localparam int unsigned EN_MF_W      = 1;
  localparam int unsigned EN_LF_POS      = 32; localparam int unsigned EN_LF_W      = 1;

  typedef logic [PAGE_W-1:0] page_t;

  // Member order mirrors the bit map above, MSB first; gd[0] is active-low.
  typedef struct packed {
    logic       en_lf;
    logic       en_mf;
    logic       en_hf;
    logic [1:0] dn;
    logic [2:0] dp;
    logic       en_rdeg;
    logic [1:0] en_rdeg_hf;
    logic [1:0] ccomp_sel;
    logic [3:0] cap_sel;
    logic [3:0] f;
    logic       iq;
    logic [3:0] gs;
    logic       ce;
    logic       ns;
    logic [2:0] gd;
    logic       fs;
    logic       re;
  } cfg_fields_t;

endpackage

// File: rtl/cfg_shift_reg.sv
// Serial configuration shift register: LSB-first load, saturating bit counter, VALID flag.
module cfg_shift_reg
  import vin_spc_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cfg_i,
  output logic [CFG_W-1:0] cfg_o,
  output logic             valid_o
);

  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full;

  assign full = (cnt_q == CNT_W'(CFG_W));

  // Once the full word is in, the register freezes and further serial data is ignored.
  always_comb begin
    cfg_d = cfg_q;
    cnt_d = cnt_q;
    if (!full) begin
      cfg_d = {cfg_i, cfg_q[CFG_W-1:1]};
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q <= '0;
      cnt_q <= '0;
    end else begin
      cfg_q <= cfg_d;
      cnt_q <= cnt_d;
    end
  end

  assign cfg_o   = cfg_q;
  assign valid_o = full;

endmodule

// File: rtl/vin_spc_top.sv
// VIN configuration top: serial config load, button-driven LED page viewer, Arduino reset.
// Build option: define LED_ACTIVE_LOW_EN for inverted LED drive (reset value all-ones).
module vin_spc_top
  import vin_spc_pkg::*;
(
  input  logic Clk,
  input  logic Resetn,
  input  logic Cfg_in,
  input  logic DIR_LEFT,
  input  logic DIR_RIGHT,
  input  logic DIR_UP,
  input  logic DIR_DOWN,
  output logic LED0,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4,
  output logic LED5,
  output logic LED6,
  output logic LED7,
  output logic ARDUINO_RESET
);

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [LED_W-1:0] LedRst = '1;
`else
  localparam logic [LED_W-1:0] LedRst = '0;
`endif

  // Asynchronous assert, synchronous release.
  logic rst_meta_q, rst_sync_q, rst_n;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign rst_n = rst_sync_q;

  logic [CFG_W-1:0] cfg_word;
  logic             valid;
  cfg_fields_t      fields;

  cfg_shift_reg u_shift (
    .clk_i   (Clk),
    .rst_ni  (rst_n),
    .cfg_i   (Cfg_in),
    .cfg_o   (cfg_word),
    .valid_o (valid)
  );

  assign fields = cfg_fields_t'(cfg_word);

  logic [NUM_BTN-1:0] btn_raw, btn_meta_q, btn_sync_q, btn_prev_q, btn_rise;
  page_t              page_q, page_d;
  logic [LED_W-1:0]   led_q, led_d, led_sel;
  logic               ard_q;

  assign btn_raw  = {DIR_DOWN, DIR_UP, DIR_RIGHT, DIR_LEFT};
  assign btn_rise = btn_sync_q & ~btn_prev_q;

  always_comb begin
    page_d = page_q;
    if (btn_rise[BTN_DOWN]) begin
      page_d = '0;
    end else if (btn_rise[BTN_UP]) begin
      page_d = page_t'(PAGE_MAX);
    end else if (btn_rise[BTN_RIGHT]) begin
      page_d = (page_q >= page_t'(PAGE_MAX)) ? '0 : page_q + page_t'(1);
    end else if (btn_rise[BTN_LEFT]) begin
      page_d = (page_q == '0) ? page_t'(PAGE_MAX) : page_q - page_t'(1);
    end
  end

  // Pages 0..3 are byte slices; the last page carries only the top bit.
  always_comb begin
    led_sel = '0;
    if (page_q < page_t'(PAGE_MAX)) begin
      led_sel = fields[{1'b0, page_q[1:0], 3'b000} +: LED_W];
    end else begin
      led_sel = {{(LED_W-1){1'b0}}, fields.en_lf};
    end
`ifdef LED_ACTIVE_LOW_EN
    led_d = ~led_sel;
`else
    led_d = led_sel;
`endif
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      btn_prev_q <= '0;
      page_q     <= '0;
      led_q      <= LedRst;
      ard_q      <= 1'b0;
    end else begin
      btn_meta_q <= btn_raw;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
      page_q     <= page_d;
      led_q      <= led_d;
      ard_q      <= valid;
    end
  end

  assign {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0} = led_q;
  assign ARDUINO_RESET = ard_q;

endmodule

// File: tb/tb_vin_spc_top.sv
// Directed bench for vin_spc_top: config load, freeze, reset handling and LED paging.
module tb_vin_spc_top;
  import vin_spc_pkg::*;

  logic Clk = 1'b0;
  logic Resetn = 1'b1;
  logic Cfg_in = 1'b0;
  logic DIR_LEFT = 1'b0, DIR_RIGHT = 1'b0, DIR_UP = 1'b0, DIR_DOWN = 1'b0;
  logic LED0, LED1, LED2, LED3, LED4, LED5, LED6, LED7, ARDUINO_RESET;
  logic [7:0] led_bus;

  localparam logic [32:0] W1 = 33'h1_7266_ADA5;
  localparam logic [32:0] W2 = 33'h0_8D99_525A;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  vin_spc_top dut (
    .Clk           (Clk),
    .Resetn        (Resetn),
    .Cfg_in        (Cfg_in),
    .DIR_LEFT      (DIR_LEFT),
    .DIR_RIGHT     (DIR_RIGHT),
    .DIR_UP        (DIR_UP),
    .DIR_DOWN      (DIR_DOWN),
    .LED0          (LED0),
    .LED1          (LED1),
    .LED2          (LED2),
    .LED3          (LED3),
    .LED4          (LED4),
    .LED5          (LED5),
    .LED6          (LED6),
    .LED7          (LED7),
    .ARDUINO_RESET (ARDUINO_RESET)
  );

  assign led_bus = {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0};

  always #5 Clk = ~Clk;

  function automatic logic [7:0] led_exp(input logic [7:0] v);
`ifdef LED_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_led(input string tag, input logic [7:0] v);
    exp_q.push_back(led_exp(v));
    tag_q.push_back(tag);
  endtask

  task automatic compare_led();
    logic [7:0] e;
    string      t;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h expected none", led_bus);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, {56'h0, led_bus}, {56'h0, e});
    end
  endtask

  task automatic reset_assert();
    Cfg_in = 1'b0;
    {DIR_DOWN, DIR_UP, DIR_RIGHT, DIR_LEFT} = 4'b0000;
    Resetn = 1'b0;
    #1;
  endtask

  task automatic reset_release();
    repeat (2) @(negedge Clk);
    Resetn = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic shift_word(input logic [32:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      Cfg_in = w[i];
      @(negedge Clk);
      if (i == 16) check("ard_low_loading", {63'h0, ARDUINO_RESET}, 64'h0);
    end
    Cfg_in = 1'b0;
  endtask

  task automatic press(input logic [3:0] mask, input string tag, input logic [7:0] v);
    expect_led(tag, v);
    {DIR_DOWN, DIR_UP, DIR_RIGHT, DIR_LEFT} = mask;
    repeat (3) @(negedge Clk);
    {DIR_DOWN, DIR_UP, DIR_RIGHT, DIR_LEFT} = 4'b0000;
    repeat (4) @(negedge Clk);
    compare_led();
  endtask

  initial begin
    #2;
    reset_assert();
    check("rst_ard", {63'h0, ARDUINO_RESET}, 64'h0);
    check("rst_led", {56'h0, led_bus}, {56'h0, led_exp(8'h00)});
    check("rst_cnt", {58'h0, dut.u_shift.cnt_q}, 64'h0);
    reset_release();
    check("cnt_after_release", {58'h0, dut.u_shift.cnt_q}, 64'h0);

    // Word 1 load
    shift_word(W1, 33);
    check("w1_cfg", {31'h0, dut.cfg_word}, {31'h0, W1});
    check("w1_cnt", {58'h0, dut.u_shift.cnt_q}, 64'd33);
    expect_led("w1_led_page0", 8'hA5);
    @(negedge Clk);
    check("w1_ard_high", {63'h0, ARDUINO_RESET}, 64'h1);
    compare_led();
    check("w1_f", {60'h0, dut.cfg_word[F_POS +: F_W]}, 64'hA);
    check("w1_gs", {60'h0, dut.cfg_word[GS_POS +: GS_W]}, 64'hB);
    check("w1_gd", {61'h0, dut.cfg_word[GD_POS +: GD_W]}, 64'h1);
    check("w1_en_lf", {63'h0, dut.cfg_word[EN_LF_POS]}, 64'h1);

    // Extra serial data after a full word is ignored
    Cfg_in = 1'b1;
    repeat (6) @(negedge Clk);
    Cfg_in = 1'b0;
    check("freeze_cfg", {31'h0, dut.cfg_word}, {31'h0, W1});
    check("freeze_cnt", {58'h0, dut.u_shift.cnt_q}, 64'd33);

    // Paging: RIGHT x5 wraps, then LEFT wraps back to page 4
    press(4'b0010, "right_p1", 8'hAD);
    press(4'b0010, "right_p2", 8'h66);
    press(4'b0010, "right_p3", 8'h72);
    press(4'b0010, "right_p4", 8'h01);
    press(4'b0010, "right_wrap_p0", 8'hA5);
    press(4'b0001, "left_wrap_p4", 8'h01);
    press(4'b1000, "down_p0", 8'hA5);
    press(4'b0110, "up_beats_right", 8'h01);
    check("page_after_up_right", {61'h0, dut.page_q}, 64'd4);
    press(4'b1000, "down_after_up", 8'hA5);

    // Reset pulse, then word 2
    reset_assert();
    check("rst2_ard", {63'h0, ARDUINO_RESET}, 64'h0);
    check("rst2_led", {56'h0, led_bus}, {56'h0, led_exp(8'h00)});
    reset_release();
    shift_word(W2, 33);
    check("w2_cfg", {31'h0, dut.cfg_word}, {31'h0, W2});
    expect_led("w2_led_page0", 8'h5A);
    @(negedge Clk);
    check("w2_ard_high", {63'h0, ARDUINO_RESET}, 64'h1);
    compare_led();

    // Partial load aborted by reset, then a clean reload
    reset_assert();
    reset_release();
    shift_word(W1, 10);
    check("partial_cfg", {31'h0, dut.cfg_word}, {31'h0, {W1[9:0], 23'h0}});
    check("partial_ard", {63'h0, ARDUINO_RESET}, 64'h0);
    reset_assert();
    check("abort_cfg", {31'h0, dut.cfg_word}, 64'h0);
    check("abort_cnt", {58'h0, dut.u_shift.cnt_q}, 64'h0);
    reset_release();
    shift_word(W1, 33);
    check("reload_cfg", {31'h0, dut.cfg_word}, {31'h0, W1});
    expect_led("reload_led", 8'hA5);
    @(negedge Clk);
    check("reload_ard", {63'h0, ARDUINO_RESET}, 64'h1);
    compare_led();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vin_spc_top.md
VIN_SPC_TOP -- requirements
Module: vin_spc_top

Interface
REQ-001 Clk  input  1  system clock; all state updates on rising edge.
REQ-002 Resetn  input  1  reset; asynchronous, active-low.
REQ-003 Cfg_in  input  1  serial configuration data, LSB (bit 0) first, sampled on rising Clk.
REQ-004 DIR_LEFT, DIR_RIGHT, DIR_UP, DIR_DOWN  input  1 each  asynchronous push-buttons, active-high.
REQ-005 LED0..LED7  output  1 each  display byte of the selected page; LED0 = LSB.
REQ-006 ARDUINO_RESET  output  1  active-low reset to external Arduino.

Function
REQ-007 Config register CFG[32:0]: shift right, Cfg_in enters CFG[32]; after 33 shifts, serial bit k resides in CFG[k].
REQ-008 Bit counter 0..33, +1 per shift; at 33 the register freezes, Cfg_in ignored, counter saturates.
REQ-009 VALID = (counter == 33).
REQ-010 Field map: RE[0], FS[1], GD[4:2], NS[5], CE[6], GS[10:7], IQ[11], F[15:12], CapSel[19:16], CcompSel[21:20], EnRdegHF[23:22], EnRdeg[24], DP[27:25], DN[29:28], EnHF[30], EnMF[31], EnLF[32].
REQ-011 Decoded fields are internal signals only; GD[2] is active-low, passed through unmodified.
REQ-012 Buttons pass through a 2-flop synchronizer and a rising-edge detector; one step per press.
REQ-013 Page pointer P, 3 bits, range 0..4: RIGHT increments (4 wraps to 0), LEFT decrements (0 wraps to 4), UP sets 4, DOWN sets 0.
REQ-014 Simultaneous edges, priority: DOWN > UP > RIGHT > LEFT.
REQ-015 LED[7:0] = CFG[8P+7:8P] for P = 0..3; for P = 4: {7'b0, CFG[32]}; registered, 1-cycle latency.
REQ-016 While VALID = 0, LEDs show the live (partially shifted) register.
REQ-017 ARDUINO_RESET = VALID, registered: low until the full word is loaded, high thereafter.

Reset
REQ-018 Resetn low clears CFG, counter, P, synchronizer/edge flops, LED outputs and ARDUINO_RESET to 0.
REQ-019 Reset asserted mid-load discards the partial word; the next load starts at bit 0.
REQ-020 Release of Resetn is synchronized to Clk before reaching the state machinery.

Configuration
REQ-021 LED_ACTIVE_LOW_EN defined: LED0..LED7 driven inverted (lit = 0) and reset to all-ones; undefined: active-high, reset to all-zeros.

Structure
REQ-022 Package vin_spc_pkg: CFG_W = 33, PAGE_MAX = 4, and bit-position/width constants for every REQ-010 field.
REQ-023 One sub-module, cfg_shift_reg: serial shift register, bit counter and VALID.

Verification
REQ-024 Reset, then shift 0x1_7266_ADA5 LSB first at 10 ns per bit -> after 33 clocks CFG = 0x1_7266_ADA5, ARDUINO_RESET = 1, LEDs = 0xA5; fields F = 0xA, GS = 0xB, GD = 3'b001, EnLF = 1.
REQ-025 Hold Cfg_in at 1 for 6 further clocks -> CFG unchanged, counter remains 33.
REQ-026 Pulse Resetn, shift 0x0_8D99_525A -> CFG = 0x0_8D99_525A, LEDs = 0x5A, ARDUINO_RESET low during loading, then high.
REQ-027 With word 1 loaded, press RIGHT five times -> LEDs 0xAD, 0x66, 0x72, 0x01, then 0xA5 (wrap); one LEFT press -> 0x01.
REQ-028 With word 1 loaded, UP and RIGHT in the same cycle -> P = 4, LEDs = 0x01; then DOWN -> LEDs = 0xA5.
REQ-029 Resetn pulsed after 10 bits -> CFG = 0, counter = 0; a following full 33-bit load completes correctly.
